control_sequencer: RTL and testbench

- Hardwired Moore control unit sitting directly upstream of the existing datapath.
- Steps the fetch cycle (T0–T2), decodes IR, then steps the execute cycle for register/immediate ALU, mul/div, nop and halt instructions.
- Drives every datapath enable, select and ALU ctrl code.
- Waits on a memory-ready handshake during the instruction read.

---
 rtl/cpu_pkg.sv | 88 ++++++++
 rtl/reg_select_decoder.sv | 14 +
 rtl/control_sequencer.sv | 170 +++++++++++++++++
 tb/tb_control_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// FSM states and instruction-register field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_REG, CL_IMM, CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;
  localparam logic [3:0] ALU_INC4 = 4'd13;

  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   return CL_REG;
      OP_ADDI, OP_ANDI, OP_ORI:          return CL_IMM;
      OP_MUL, OP_DIV:                    return CL_MULDIV;
      OP_NEG, OP_NOT:                    return CL_UNARY;
      OP_NOP:                            return CL_NOP;
      OP_HALT:                           return CL_HALT;
      default:                           return CL_ILLEGAL;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHRA:         return ALU_SHRA;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register field into a one-hot register strobe, all-zero when
// the enable is low.
module reg_select_decoder (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2), decode (T3), execute (T4-T6)
// for the register, immediate, mul/div, unary, nop and halt instructions.
//
//   state   | meaning
//   S_RESET | post-Clear hold, only Run asserted
//   S_T0    | PC -> MAR, PC+4 into Z
//   S_T1    | Z -> PC, memory read into MDR; waits for Mem_ready
//   S_T2    | MDR -> IR
//   S_T3    | decode; operand A into Y for binary ops
//   S_T4    | ALU execute into Z (and Zhigh for mul/div)
//   S_T5    | Zlow -> Ra or LO
//   S_T6    | Zhigh -> HI (mul/div only)
//   S_HALT  | stopped until Clear, Run low
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IRdata,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Cout,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [3:0]  ctrl,
  output logic        Run,
  output logic        Illegal
);

  localparam int CW = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(RESET_PC_HOLD - 1);

  state_t        state;
  logic [CW-1:0] hold_cnt;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  op_class_t  cls;

  assign op  = IRdata[OP_MSB:OP_LSB];
  assign ra  = IRdata[RA_MSB:RA_LSB];
  assign rb  = IRdata[RB_MSB:RB_LSB];
  assign rc  = IRdata[RC_MSB:RC_LSB];
  assign cls = classify(op);

  // The low immediate bits reach the bus through the datapath, not through here.
  logic unused_ir;
  assign unused_ir = ^IRdata[RC_LSB-1:0];

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= S_RESET;
      hold_cnt <= HOLD_INIT;
    end else begin
      case (state)
        S_RESET: begin
          if (hold_cnt == '0) state <= S_T0;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        S_T0: state <= S_T1;
        S_T1: if (Mem_ready) state <= S_T2;
        S_T2: state <= S_T3;
        S_T3: begin
          case (cls)
            CL_NOP, CL_ILLEGAL: state <= S_T0;
            CL_HALT:            state <= S_HALT;
            default:            state <= S_T4;
          endcase
        end
        S_T4:    state <= S_T5;
        S_T5:    state <= (cls == CL_MULDIV) ? S_T6 : S_T0;
        S_T6:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  logic       rin_en, rout_en;
  logic [3:0] rout_field;

  always_comb begin
    {PCout, MARin, IncPC, Zlowin, Zhighin, Zlowout, Zhighout, PCin} = '0;
    {Read, MDRin, MDRout, IRin, Yin, HIin, LOin, Cout} = '0;
    ctrl       = '0;
    Run        = 1'b1;
    Illegal    = 1'b0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_field = rb;
    case (state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
        ctrl   = ALU_INC4;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (cls inside {CL_REG, CL_IMM, CL_MULDIV}) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
        end
        Illegal = (cls == CL_ILLEGAL);
      end
      S_T4: begin
        ctrl    = alu_code(op);
        Zlowin  = 1'b1;
        Zhighin = (cls == CL_MULDIV);
        Cout    = (cls == CL_IMM);
        if (cls inside {CL_REG, CL_MULDIV}) begin
          rout_en    = 1'b1;
          rout_field = rc;
        end else if (cls == CL_UNARY) begin
          rout_en = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        LOin    = (cls == CL_MULDIV);
        rin_en  = (cls inside {CL_REG, CL_IMM, CL_UNARY});
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_HALT:  Run = 1'b0;
      default: ;
    endcase
  end

  reg_select_decoder u_rin_dec (
    .field  (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_select_decoder u_rout_dec (
    .field  (rout_field),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class through
// its states and compares the full output word against hand-built vectors.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IRdata = '0;
  logic        Mem_ready = 1'b1;
  logic PCout, MARin, IncPC, Zlowin, Zhighin, Zlowout, Zhighout, PCin;
  logic Read, MDRin, MDRout, IRin, Yin, HIin, LOin, Cout;
  logic [15:0] Rin, Rout;
  logic [3:0]  ctrl;
  logic        Run, Illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clock = ~Clock;

  control_sequencer #(.RESET_PC_HOLD(1)) dut (
    .Clock(Clock), .Clear(Clear), .IRdata(IRdata), .Mem_ready(Mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin),
    .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Cout(Cout), .Rin(Rin), .Rout(Rout),
    .ctrl(ctrl), .Run(Run), .Illegal(Illegal)
  );

  localparam logic [15:0] C_PCOUT = 16'h8000, C_MARIN = 16'h4000, C_INCPC = 16'h2000;
  localparam logic [15:0] C_ZLOWIN = 16'h1000, C_ZHIGHIN = 16'h0800, C_ZLOWOUT = 16'h0400;
  localparam logic [15:0] C_ZHIGHOUT = 16'h0200, C_PCIN = 16'h0100, C_READ = 16'h0080;
  localparam logic [15:0] C_MDRIN = 16'h0040, C_MDROUT = 16'h0020, C_IRIN = 16'h0010;
  localparam logic [15:0] C_YIN = 16'h0008, C_HIIN = 16'h0004, C_LOIN = 16'h0002;
  localparam logic [15:0] C_COUT = 16'h0001;

  logic [15:0] ctl;
  logic [53:0] obs;
  assign ctl = {PCout, MARin, IncPC, Zlowin, Zhighin, Zlowout, Zhighout, PCin,
                Read, MDRin, MDRout, IRin, Yin, HIin, LOin, Cout};
  assign obs = {ctl, Rin, Rout, ctrl, Run, Illegal};

  function automatic logic [53:0] mk(input logic [15:0] c, input logic [15:0] rin,
                                     input logic [15:0] rout, input logic [3:0] alu,
                                     input logic run, input logic ill);
    return {c, rin, rout, alu, run, ill};
  endfunction

  function automatic logic [31:0] ir(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [18:0] low);
    return {op, ra, rb, low};
  endfunction

  logic [53:0] E_RST, E_T0, E_T1, E_T2, E_HALT;
  initial begin
    E_RST  = mk(16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    E_T0   = mk(C_PCOUT | C_MARIN | C_INCPC | C_ZLOWIN, 16'h0, 16'h0, 4'd13, 1'b1, 1'b0);
    E_T1   = mk(C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    E_T2   = mk(C_MDROUT | C_IRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    E_HALT = mk(16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
  end

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic run_fetch();
    step(); step(); step();
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    IRdata = ir(5'b00011, 4'd3, 4'd1, {4'd2, 15'h0});
    step(); step();
    total_cnt++;
    if (obs !== E_RST) $display("FAIL reset_state obs=%h exp=%h", obs, E_RST);
    else pass_cnt++;
    Clear = 1'b0;
    step();
    total_cnt++;
    if (obs !== E_T0) $display("FAIL reset_to_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [53:0] exp_seq [5];
    exp_seq[0] = E_T1;
    exp_seq[1] = E_T2;
    exp_seq[2] = mk(C_YIN, 16'h0, 16'h0002, 4'd0, 1'b1, 1'b0);
    exp_seq[3] = mk(C_ZLOWIN, 16'h0, 16'h0004, 4'd0, 1'b1, 1'b0);
    exp_seq[4] = mk(C_ZLOWOUT, 16'h0008, 16'h0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (obs !== exp_seq[i]) $display("FAIL add_cycle%0d obs=%h exp=%h", i + 1, obs, exp_seq[i]);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (obs !== E_T0) $display("FAIL add_next_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
  endtask

  task automatic test_mem_wait();
    int irin_cnt = 0;
    int t1_bad = 0;
    Mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs !== E_T1) t1_bad++;
      if (IRin) irin_cnt++;
    end
    total_cnt++;
    if (t1_bad != 0) $display("FAIL wait_t1_held bad_cycles=%0d exp=0", t1_bad);
    else pass_cnt++;
    Mem_ready = 1'b1;
    step();
    total_cnt++;
    if (obs !== E_T2) $display("FAIL wait_t2 obs=%h exp=%h", obs, E_T2);
    else pass_cnt++;
    if (IRin) irin_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (IRin) irin_cnt++;
    end
    total_cnt++;
    if (irin_cnt != 1) $display("FAIL wait_irin_once count=%0d exp=1", irin_cnt);
    else pass_cnt++;
    total_cnt++;
    if (obs !== E_T0) $display("FAIL wait_next_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    logic [53:0] exp_seq [4];
    logic [15:0] rin_or = '0;
    IRdata = ir(5'b01111, 4'd7, 4'd5, {4'd6, 15'h0});
    exp_seq[0] = mk(C_YIN, 16'h0, 16'h0020, 4'd0, 1'b1, 1'b0);
    exp_seq[1] = mk(C_ZLOWIN | C_ZHIGHIN, 16'h0, 16'h0040, 4'd9, 1'b1, 1'b0);
    exp_seq[2] = mk(C_ZLOWOUT | C_LOIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    exp_seq[3] = mk(C_ZHIGHOUT | C_HIIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    run_fetch();
    for (int i = 0; i < 4; i++) begin
      rin_or |= Rin;
      total_cnt++;
      if (obs !== exp_seq[i]) $display("FAIL mul_t%0d obs=%h exp=%h", i + 3, obs, exp_seq[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (obs !== E_T0) $display("FAIL mul_next_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
    total_cnt++;
    if (rin_or !== 16'h0) $display("FAIL mul_no_rin obs=%h exp=0000", rin_or);
    else pass_cnt++;
  endtask

  task automatic test_addi();
    logic [53:0] exp_seq [3];
    IRdata = ir(5'b01100, 4'd2, 4'd4, 19'h7FFFB);
    exp_seq[0] = mk(C_YIN, 16'h0, 16'h0010, 4'd0, 1'b1, 1'b0);
    exp_seq[1] = mk(C_ZLOWIN | C_COUT, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    exp_seq[2] = mk(C_ZLOWOUT, 16'h0004, 16'h0, 4'd0, 1'b1, 1'b0);
    run_fetch();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (obs !== exp_seq[i]) $display("FAIL addi_t%0d obs=%h exp=%h", i + 3, obs, exp_seq[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (obs !== E_T0) $display("FAIL addi_next_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
  endtask

  task automatic test_illegal_halt();
    logic [53:0] exp_ill;
    int halt_bad = 0;
    exp_ill = mk(16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1);
    IRdata = ir(5'b11111, 4'd1, 4'd2, {4'd3, 15'h0});
    run_fetch();
    total_cnt++;
    if (obs !== exp_ill) $display("FAIL illegal_t3 obs=%h exp=%h", obs, exp_ill);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== E_T0) $display("FAIL illegal_next_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
    IRdata = ir(5'b11011, 4'd0, 4'd0, 19'h0);
    run_fetch();
    total_cnt++;
    if (obs !== E_RST) $display("FAIL halt_t3 obs=%h exp=%h", obs, E_RST);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs !== E_HALT) halt_bad++;
    end
    total_cnt++;
    if (halt_bad != 0) $display("FAIL halt_hold bad_cycles=%0d exp=0", halt_bad);
    else pass_cnt++;
  endtask

  task automatic test_clear_abort();
    logic [53:0] exp_t4;
    logic [15:0] rin_or = '0;
    exp_t4 = mk(C_ZLOWIN, 16'h0, 16'h0008, 4'd1, 1'b1, 1'b0);
    Clear = 1'b1;
    step();
    total_cnt++;
    if (obs !== E_RST) $display("FAIL clear_from_halt obs=%h exp=%h", obs, E_RST);
    else pass_cnt++;
    Clear = 1'b0;
    step();
    total_cnt++;
    if (obs !== E_T0) $display("FAIL clear_halt_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
    IRdata = ir(5'b00100, 4'd1, 4'd2, {4'd3, 15'h0});
    run_fetch();
    step();
    total_cnt++;
    if (obs !== exp_t4) $display("FAIL sub_t4 obs=%h exp=%h", obs, exp_t4);
    else pass_cnt++;
    Clear = 1'b1;
    step();
    rin_or |= Rin;
    total_cnt++;
    if (obs !== E_RST) $display("FAIL abort_reset obs=%h exp=%h", obs, E_RST);
    else pass_cnt++;
    Clear = 1'b0;
    step();
    rin_or |= Rin;
    total_cnt++;
    if (obs !== E_T0) $display("FAIL abort_t0 obs=%h exp=%h", obs, E_T0);
    else pass_cnt++;
    total_cnt++;
    if (rin_or !== 16'h0) $display("FAIL abort_no_rin obs=%h exp=0000", rin_or);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_add();
    test_mem_wait();
    test_mul();
    test_addi();
    test_illegal_halt();
    test_clear_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
